// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The FSM state enum is used by the top; the lane constants are used by the packer.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 4-byte word assembler: word_valid pulses combinationally with the
// fourth accepted byte; clr returns the lane counter to lane 0.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  lane;
  logic [23:0] sreg;

  // Earlier bytes shift down, so after three bytes sreg[7:0] holds byte 0.
  assign word       = {data, sreg};
  assign word_valid = take && (lane == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      lane <= 2'd0;
      sreg <= 24'd0;
    end else if (take) begin
      lane <= lane + 2'd1;
      sreg <= {data, sreg[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream programmer for the instruction memory; one registered
// word write per 4 bytes, no memory backpressure. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  state_t      state;
  logic [31:0] len_n;
  logic        take;
  logic        word_valid;
  logic [31:0] word;
  logic [32:0] wl_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum;
`endif

  assign take    = in_valid && in_ready;
  assign wl_next = 33'(words_loaded) + 33'd1;

  // in_ready is low in every non-accepting state, which also resets the lane on entry.
  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (!in_ready),
    .take       (take),
    .data       (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= 32'd0;
      core_hold    <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      len_n        <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum          <= 32'd0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN;
            in_ready     <= 1'b1;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum          <= 32'd0;
`endif
          end
        end

        S_LEN: begin
          if (word_valid) begin
            len_n <= word;
            if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state     <= S_CSUM;
`else
              state     <= S_DONE;
              in_ready  <= 1'b0;
              core_hold <= 1'b0;
              done      <= 1'b1;
`endif
            end else if ({1'b0, word} > MAX_WORDS) begin
              state     <= S_ERR;
              in_ready  <= 1'b0;
              core_hold <= 1'b0;
              err       <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (word_valid) begin
            mem_we       <= 1'b1;
            mem_waddr    <= words_loaded[ADDR_W-1:0];
            mem_wdata    <= word;
            words_loaded <= words_loaded + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum          <= sum + word;
`endif
            if (wl_next == {1'b0, len_n}) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state     <= S_CSUM;
`else
              state     <= S_DONE;
              in_ready  <= 1'b0;
              core_hold <= 1'b0;
              done      <= 1'b1;
`endif
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (word_valid) begin
            in_ready  <= 1'b0;
            core_hold <= 1'b0;
            if (word == sum) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=4): byte-stream model checked every cycle
// plus literal expectations after each scenario.
module tb_imem_loader;

  localparam int     ADDR_W = 4;
  localparam longint MAXW   = 16;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int     CS     = 4;
`else
  localparam int     CS     = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .core_hold    (core_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the stream semantics: expectations for the cycle after each edge.
  logic        e_ready = 1'b0, e_we = 1'b0, e_hold = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [3:0]  e_waddr = 4'd0;
  logic [31:0] e_wdata = 32'd0;
  int          e_wl = 0;
  logic [7:0]  q[$];

  logic [3:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  function automatic logic [31:0] word_at(input int i);
    return {q[i+3], q[i+2], q[i+1], q[i]};
  endfunction

  task automatic m_finish(input bit ok);
    e_ready = 1'b0;
    e_hold  = 1'b0;
    e_done  = ok;
    e_err   = !ok;
  endtask

  task automatic predict();
    int          k;
    longint      n;
    logic [31:0] s;
    if (!rst) begin
      {e_ready, e_we, e_hold, e_done, e_err} = 5'b0;
      e_wl = 0;
      q.delete();
    end else begin
      e_we = 1'b0;
      if (e_ready && in_valid) begin
        q.push_back(in_data);
        k = q.size();
        if (k >= 4) begin
          n = longint'(word_at(0));
          if (k == 4 && n > MAXW) begin
            m_finish(1'b0);
          end else begin
            if (k > 4 && longint'(k) <= 4 + 4 * n && k % 4 == 0) begin
              e_we    = 1'b1;
              e_waddr = 4'((k - 8) / 4);
              e_wdata = word_at(k - 4);
              e_wl    = (k - 4) / 4;
            end
            if (longint'(k) == 4 + 4 * n + CS) begin
              s = 32'd0;
              for (int j = 0; j < int'(n); j++) s += word_at(4 + 4 * j);
              m_finish(CS == 0 || word_at(k - 4) == s);
            end
          end
        end
      end else if (start && !e_hold) begin
        e_ready = 1'b1;
        e_hold  = 1'b1;
        e_done  = 1'b0;
        e_err   = 1'b0;
        e_wl    = 0;
        q.delete();
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("core_hold", 32'(core_hold), 32'(e_hold));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
      chk("words_loaded", 32'(words_loaded), 32'(e_wl));
      if (e_we) begin
        chk("mem_waddr", 32'(mem_waddr), 32'(e_waddr));
        chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (mem_we) begin
        wr_addr.push_back(mem_waddr);
        wr_data.push_back(mem_wdata);
      end
      predict();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected end before 500000");
    $fatal(1);
  end

  // Driver.
  logic [31:0] img[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit burst, input bit with_start);
    int guard;
    bit acc;
    if (burst) repeat ($urandom_range(0, 2)) tick();
    in_valid = 1'b1;
    in_data  = b;
    start    = with_start;
    guard    = 0;
    acc      = 1'b0;
    while (!acc && guard <= 20) begin
      acc = in_ready;
      tick();
      start = 1'b0;
      guard++;
    end
    if (!acc) begin
      n_checks++;
      n_err++;
      $display("FAIL byte_accept_timeout: in_ready stayed 0, expected 1 within 20 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit burst, input bit start_last);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], burst, start_last && i == 3);
  endtask

  task automatic do_load(input bit burst, input bit csum_bad, input bit start_last,
                         input bit mid_start);
    logic [31:0] s;
    s = 32'd0;
    wr_addr.delete();
    wr_data.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(32'(img.size()), burst, start_last && img.size() == 0 && CS == 0);
    if (mid_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < img.size(); i++) begin
      send_word(img[i], burst, start_last && i == img.size() - 1 && CS == 0);
      s += img[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(s + 32'(csum_bad), burst, start_last);
`else
    s = s + 32'(csum_bad);
`endif
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_core_hold"}, 32'(core_hold), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_mem_waddr"}, 32'(mem_waddr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Basic load, with a start pulse on the terminating byte that must be ignored.
    img = '{32'h00500113, 32'h00212223, 32'h00412183};
    do_load(1'b0, 1'b0, 1'b1, 1'b0);
    chk("basic_nwrites", 32'(wr_addr.size()), 32'd3);
    if (wr_addr.size() == 3) begin
      chk("basic_addr0", 32'(wr_addr[0]), 32'd0);
      chk("basic_addr2", 32'(wr_addr[2]), 32'd2);
      chk("basic_data0", wr_data[0], 32'h00500113);
      chk("basic_data1", wr_data[1], 32'h00212223);
      chk("basic_data2", wr_data[2], 32'h00412183);
    end
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_hold", 32'(core_hold), 32'd0);
    chk("basic_wl", 32'(words_loaded), 32'd3);

    // Empty image.
    img = {};
    do_load(1'b0, 1'b0, 1'b0, 1'b0);
    chk("empty_nwrites", 32'(wr_addr.size()), 32'd0);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_wl", 32'(words_loaded), 32'd0);

    // Oversize: 17 words into a 16-word memory.
    wr_addr.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(32'd17, 1'b0, 1'b0);
    tick();
    chk("over_err", 32'(err), 32'd1);
    chk("over_done", 32'(done), 32'd0);
    chk("over_ready", 32'(in_ready), 32'd0);
    chk("over_nwrites", 32'(wr_addr.size()), 32'd0);

    // Exactly full memory.
    img = {};
    for (int i = 0; i < 16; i++) img.push_back(32'h01010101 * (i + 1));
    do_load(1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_done", 32'(done), 32'd1);
    chk("full_wl", 32'(words_loaded), 32'd16);
    chk("full_last_addr", 32'(wr_addr[$]), 32'd15);
    chk("full_last_data", wr_data[$], 32'h10101010);

    // Bursty input with an ignored start while loading.
    img = '{32'hDEADBEEF, 32'h12345678};
    do_load(1'b1, 1'b0, 1'b0, 1'b1);
    chk("burst_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_data.size() == 2) begin
      chk("burst_data0", wr_data[0], 32'hDEADBEEF);
      chk("burst_data1", wr_data[1], 32'h12345678);
      chk("burst_addr1", 32'(wr_addr[1]), 32'd1);
    end
    chk("burst_done", 32'(done), 32'd1);

    // Reset after 6 of 12 data bytes, then a clean reload.
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(32'd3, 1'b0, 1'b0);
    send_word(32'hA1B2C3D4, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b1;
    img = '{32'h00000013, 32'h00100093, 32'h00208133};
    do_load(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reload_nwrites", 32'(wr_addr.size()), 32'd3);
    if (wr_data.size() == 3) chk("reload_data2", wr_data[2], 32'h00208133);
    chk("reload_wl", 32'(words_loaded), 32'd3);
    chk("reload_done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    img = '{32'd1, 32'd2};
    do_load(1'b0, 1'b0, 1'b0, 1'b0);
    chk("csum_good_done", 32'(done), 32'd1);
    do_load(1'b0, 1'b1, 1'b0, 1'b0);
    chk("csum_bad_err", 32'(err), 32'd1);
    chk("csum_bad_done", 32'(done), 32'd0);
    do_load(1'b0, 1'b0, 1'b0, 1'b0);
    chk("csum_restart_done", 32'(done), 32'd1);
    chk("csum_restart_wl", 32'(words_loaded), 32'd2);
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream programmer for the RV32I instruction memory: accepts a length-prefixed little-endian byte stream, packs it into 32-bit words and issues one word write per instruction slot, starting at word address 0. It is the write side of the instruction memory, whose read port is indexed by `PC[31:2]`. While a load is in progress it asserts `core_hold`, which keeps the processor in reset.

## Interface
- `ADDR_W`, 22: word-address width; the memory holds 2**ADDR_W words.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `in_valid` input 1: `in_data` holds a valid byte.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `mem_we` output 1: word write strobe, one cycle per word.
- `mem_waddr` output ADDR_W: word address, which equals `PC[31:2]` of the instruction.
- `mem_wdata` output 32: instruction word.
- `core_hold` output 1: high from a honoured `start` until DONE or ERR is entered.
- `done` output 1: level; high in DONE.
- `err` output 1: level; high in ERR.
- `words_loaded` output ADDR_W+1: count of words written in the current or last load.

## Operation
- A byte is accepted when `in_valid && in_ready`. Bytes are little-endian; the first accepted byte is bits [7:0].
- States:
  - IDLE -> LEN on `start`.
  - LEN: accept 4 bytes as word count N.
    - N == 0 -> DONE.
    - N > 2**ADDR_W -> ERR.
    - otherwise -> DATA.
  - DATA: accept 4·N bytes. Each fourth byte completes a word, which is written at address `words_loaded`; the counter then increments.
    - After word N: -> CSUM if the macro is defined, else -> DONE.
  - CSUM: see Configuration.
  - DONE / ERR: hold. `start` -> LEN; `words_loaded` clears to 0.
- `in_ready` is 1 in LEN, DATA and CSUM and 0 in all other states. The block applies no backpressure from memory.
- Byte-lane counter is 2 bits and clears on every state entry. The address counter never wraps because N ≤ 2**ADDR_W is checked.
- `start` arriving in LEN, DATA or CSUM is ignored.
- A `start` in the same cycle as the final accepted byte is ignored: the FSM is not yet in DONE.
- Reset mid-load: all state clears. Already-written words stay in memory, but `words_loaded` reads 0.
- Reset values:
  - state IDLE.
  - `in_ready`, `mem_we`, `core_hold`, `done`, `err` = 0.
  - `mem_waddr`, `mem_wdata`, `words_loaded` = 0.

## Timing
- Write latency: `mem_we` is high the cycle after the fourth byte of a word is accepted, with `mem_waddr` and `mem_wdata` registered and stable for that cycle.
- Throughput: one byte per cycle, so at most one write every 4 cycles.
- `core_hold` rises the cycle after `start`.
- `core_hold` falls, and `done`/`err` rise, the cycle after the terminating byte is accepted. For DONE this is the same cycle as the final `mem_we`.
- `done` and `err` are never high together.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After DATA, enter CSUM and accept 4 more bytes as value C.
  - `S` = modulo-2^32 sum of all N data words.
  - C == S -> DONE; otherwise -> ERR.
  - When N == 0, CSUM is still entered and C must equal 0.
- `IMEM_LOADER_CHECKSUM_EN` undefined: CSUM and the sum accumulator are absent; DATA -> DONE and LEN(N=0) -> DONE.

## Structure
- Package `imem_loader_pkg`:
  - state enum (IDLE, LEN, DATA, CSUM, DONE, ERR).
  - `BYTES_PER_WORD` = 4.
  - `LEN_BYTES` = 4.
- Sub-module `byte_packer`:
  - 4-byte little-endian shift assembler with a 2-bit lane counter and a `word_valid` pulse.
  - Reused by all three accepting states.

## Test plan
- Basic load: N=3, words 0x00500113, 0x00212223, 0x00412183 -> three `mem_we` pulses at addresses 0, 1, 2 with exactly those data values; `done`=1, `words_loaded`=3, `core_hold` falls.
- Empty image: N=0 -> DONE with no `mem_we`. With the checksum macro defined, the bench also sends C=0 -> DONE.
- Oversize image: ADDR_W=4, N=17 -> ERR after the fourth length byte; no writes; `in_ready`=0.
- Bursty input: `in_valid` toggled randomly across N=2 -> identical writes, each appearing one cycle after its fourth accepted byte.
- Reset mid-load: `rst`=0 after 6 of 12 data bytes -> all outputs return to reset values the next cycle. A subsequent `start` with a full stream loads correctly.
- Checksum (macro defined): words 1, 2 with C=3 -> DONE; the same words with C=4 -> ERR. `start` received while in ERR restarts the load.
